// File: rtl/rr_reg_write_encoder.sv
`default_nettype none
// ============================================================================
// Module   : rr_reg_write_encoder
// Purpose  : Round-robin 8:3 encoder for register-file write requests. Picks
//            one requester, holds its index/one-hot grant until Ack or until
//            the grant has been held TIMEOUT cycles, then rotates priority.
// Revision : 1.0 - initial release
// ============================================================================
module rr_reg_write_encoder #(
  parameter int TIMEOUT = 15,
  parameter int CW      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] Req,
  input  logic       Ack,
  output logic       A0,
  output logic       A1,
  output logic       A2,
  output logic       Enable,
  output logic [7:0] Grant,
  output logic       Timeout
);

  // Last count value before a held grant is aborted.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t      state, next_state;
  logic [2:0]  ptr, next_ptr;
  logic [2:0]  idx, next_idx;
  logic [CW-1:0] cnt, next_cnt;
  logic [7:0]  grant_q, next_grant;
  logic        enable_q, next_enable;
  logic        timeout_q, next_timeout;

  logic [2:0]  winner;
  logic [2:0]  cand;
  logic        found;

  // Rotating priority scan starting at ptr; first set request wins.
  always_comb begin
    winner = 3'd0;
    cand   = 3'd0;
    found  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cand = ptr + 3'(i);
      if (!found && Req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    next_state   = state;
    next_ptr     = ptr;
    next_idx     = idx;
    next_cnt     = cnt;
    next_grant   = grant_q;
    next_enable  = enable_q;
    next_timeout = 1'b0;
    case (state)
      IDLE: begin
        // Ack in IDLE carries no meaning and is ignored.
        if (found) begin
          next_state          = GRANT;
          next_idx            = winner;
          next_grant          = 8'd0;
          next_grant[winner]  = 1'b1;
          next_enable         = 1'b1;
          next_cnt            = '0;
        end
      end
      GRANT: begin
        // Ack takes precedence over a simultaneous timeout.
        if (Ack || (cnt == CNT_LAST)) begin
          next_state   = IDLE;
          next_ptr     = idx + 3'd1;
          next_idx     = 3'd0;
          next_grant   = 8'd0;
          next_enable  = 1'b0;
          next_timeout = ~Ack;
        end else begin
          next_cnt = cnt + 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      idx       <= 3'd0;
      cnt       <= '0;
      grant_q   <= 8'd0;
      enable_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state     <= next_state;
      ptr       <= next_ptr;
      idx       <= next_idx;
      cnt       <= next_cnt;
      grant_q   <= next_grant;
      enable_q  <= next_enable;
      timeout_q <= next_timeout;
    end
  end

  assign A0      = idx[0];
  assign A1      = idx[1];
  assign A2      = idx[2];
  assign Enable  = enable_q;
  assign Grant   = grant_q;
  assign Timeout = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_reg_write_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_reg_write_encoder
// Purpose  : Directed self-checking bench for rr_reg_write_encoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_reg_write_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] Req;
  logic       Ack;
  logic       A0, A1, A2;
  logic       Enable;
  logic [7:0] Grant;
  logic       Timeout;

  int n_cmp = 0;
  int n_bad = 0;

  rr_reg_write_encoder #(.TIMEOUT(15), .CW(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .Req     (Req),
    .Ack     (Ack),
    .A0      (A0),
    .A1      (A1),
    .A2      (A2),
    .Enable  (Enable),
    .Grant   (Grant),
    .Timeout (Timeout)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Full output snapshot against expected enable/index/grant/timeout.
  task automatic check_all(input string tag, input logic en, input logic [2:0] a,
                           input logic [7:0] g, input logic to);
    check({tag, ".en"},   {7'd0, Enable}, {7'd0, en});
    check({tag, ".addr"}, {5'd0, A2, A1, A0}, {5'd0, a});
    check({tag, ".grant"}, Grant, g);
    check({tag, ".tmo"},  {7'd0, Timeout}, {7'd0, to});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; Req = 8'hFF; Ack = 1'b0;
    // 1. reset with requests pending
    tick(); tick();
    check_all("reset", 1'b0, 3'd0, 8'h00, 1'b0);
    rst = 1'b0; Req = 8'h00;
    tick();
    check_all("idle_noreq", 1'b0, 3'd0, 8'h00, 1'b0);

    // 2. single requester 5, Ack two cycles into the grant
    Req = 8'h20;
    tick();
    check_all("r5_c1", 1'b1, 3'd5, 8'h20, 1'b0);
    tick();
    check_all("r5_c2", 1'b1, 3'd5, 8'h20, 1'b0);
    Ack = 1'b1; Req = 8'h00;
    tick();
    check_all("r5_close", 1'b0, 3'd0, 8'h00, 1'b0);
    Ack = 1'b0;
    // ptr is now 6: with 0 and 6 requesting, 6 must win
    Req = 8'h41;
    tick();
    check_all("ptr6", 1'b1, 3'd6, 8'h40, 1'b0);
    Ack = 1'b1; Req = 8'h00;
    tick();
    Ack = 1'b0;

    // 4. ptr=7, requesters 7 and 0: 7 first then 0
    Req = 8'h81;
    tick();
    check_all("wrap_7", 1'b1, 3'd7, 8'h80, 1'b0);
    Ack = 1'b1;
    tick();
    check_all("wrap_gap", 1'b0, 3'd0, 8'h00, 1'b0);
    Ack = 1'b0;
    tick();
    check_all("wrap_0", 1'b1, 3'd0, 8'h01, 1'b0);
    Ack = 1'b1; Req = 8'h00;
    tick();
    Ack = 1'b0;

    // 3. all requesting from ptr=0: order 0..7,0
    rst = 1'b1;
    tick();
    rst = 1'b0; Req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      logic [7:0] g;
      g = 8'h00;
      g[i % 8] = 1'b1;
      tick();
      check_all($sformatf("rr%0d", i), 1'b1, 3'(i % 8), g, 1'b0);
      Ack = 1'b1;
      tick();
      check({$sformatf("rr%0d", i), ".gap"}, {7'd0, Enable}, 8'h00);
      Ack = 1'b0;
    end
    Req = 8'h00;

    // Ack in IDLE is ignored
    Ack = 1'b1;
    tick();
    check_all("idle_ack", 1'b0, 3'd0, 8'h00, 1'b0);
    Ack = 1'b0;

    // 5. requester 2, never acknowledged; request dropped (grant is sticky)
    Req = 8'h04;
    tick();
    check_all("tmo_c1", 1'b1, 3'd2, 8'h04, 1'b0);
    Req = 8'h00;
    for (int i = 2; i <= 15; i++) begin
      tick();
      check_all($sformatf("tmo_c%0d", i), 1'b1, 3'd2, 8'h04, 1'b0);
    end
    tick();
    check_all("tmo_pulse", 1'b0, 3'd0, 8'h00, 1'b1);
    tick();
    check_all("tmo_after", 1'b0, 3'd0, 8'h00, 1'b0);

    // Ack on the timeout edge: Ack wins, no pulse
    Req = 8'h04;
    tick();
    check_all("ackt_c1", 1'b1, 3'd2, 8'h04, 1'b0);
    Req = 8'h00;
    for (int i = 2; i <= 15; i++) tick();
    check_all("ackt_c15", 1'b1, 3'd2, 8'h04, 1'b0);
    Ack = 1'b1;
    tick();
    check_all("ackt_close", 1'b0, 3'd0, 8'h00, 1'b0);
    Ack = 1'b0;
    tick();
    check_all("ackt_after", 1'b0, 3'd0, 8'h00, 1'b0);

    // 6. reset in the middle of a grant
    Req = 8'h08;
    tick();
    check_all("mid_grant", 1'b1, 3'd3, 8'h08, 1'b0);
    rst = 1'b1;
    tick();
    check_all("mid_rst", 1'b0, 3'd0, 8'h00, 1'b0);
    rst = 1'b0; Req = 8'h00;
    tick(); tick(); tick();
    check_all("post_rst_idle", 1'b0, 3'd0, 8'h00, 1'b0);
    // ptr restored to 0
    Req = 8'hFF;
    tick();
    check_all("post_rst_ptr", 1'b1, 3'd0, 8'h01, 1'b0);
    Req = 8'h00; Ack = 1'b1;
    tick();
    Ack = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
